// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame transmitter.
// The FSM state type, default frame geometry and small elaboration helpers live here.
package serial_frame_pkg;

  localparam int                    DEF_SEQ_W  = 4;
  localparam logic [DEF_SEQ_W-1:0]  DEF_SEQ    = 4'b1101;
  localparam int                    DEF_LEN_W  = 3;
  localparam int                    DEF_DATA_W = 8;
  localparam int                    DEF_GAP    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_DATA,
    ST_GAP
  } state_e;

  // Line cycles occupied by one frame, excluding the idle gap.
  function automatic int frame_len(input int seq_w, input int len_w, input int len);
    return seq_w + len_w + len;
  endfunction

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register; presents the LSB and shifts toward it.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shift,
  output logic         o_lsb
);

  logic [W-1:0] r_sh;

  always_ff @(posedge clk) begin
    // NOTE: the payload register is cleared on reset so an abandoned frame leaves nothing behind.
    if (!rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {1'b0, r_sh[W-1:1]};
    end
  end

  assign o_lsb = r_sh[0];

endmodule

// File: rtl/serial_frame_sender.sv
// Serialises a frame: sync pattern, length field (MSB first), payload (LSB first), idle gap.
// Outputs are registered from the next-state decode, so each bit appears the cycle after its state is entered.
module serial_frame_sender
  import serial_frame_pkg::*;
#(
  parameter int                SEQ_W  = DEF_SEQ_W,
  parameter logic [SEQ_W-1:0]  SEQ    = DEF_SEQ,
  parameter int                LEN_W  = DEF_LEN_W,
  parameter int                DATA_W = DEF_DATA_W,
  parameter int                GAP    = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [DATA_W-1:0] in_data,
  output logic              serOut,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max_of4(SEQ_W, LEN_W, DATA_W, GAP) + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [LEN_W-1:0]   r_len;
  logic               w_accept;
  logic               w_shift;
  logic               w_piso_lsb;
  logic               w_seq_bit;
  logic               w_len_bit;
  logic               w_ser_nxt;
  logic               w_done_nxt;

  assign in_ready = (r_state == ST_IDLE) && rst;
  assign w_accept = in_valid && in_ready;

  // r_cnt holds the index of the bit currently on the line; it counts down to 0 in every state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SYNC;
          w_cnt_nxt   = CNT_W'(SEQ_W - 1);
        end
      end
      ST_SYNC: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LEN;
          w_cnt_nxt   = CNT_W'(LEN_W - 1);
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_LEN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end else if (r_len != '0) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = CNT_W'(r_len) - CNT_W'(1);
        end else begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = CNT_W'(GAP - 1);
        end
      end
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = CNT_W'(GAP - 1);
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_seq_bit = 1'b0;
    w_len_bit = 1'b0;
    for (int i = 0; i < SEQ_W; i++) begin
      if (w_cnt_nxt == CNT_W'(i)) w_seq_bit = SEQ[i];
    end
    for (int i = 0; i < LEN_W; i++) begin
      if (w_cnt_nxt == CNT_W'(i)) w_len_bit = r_len[i];
    end
  end

  always_comb begin
    w_ser_nxt = 1'b0;
    case (w_state_nxt)
      ST_SYNC: w_ser_nxt = w_seq_bit;
      ST_LEN:  w_ser_nxt = w_len_bit;
      ST_DATA: w_ser_nxt = w_piso_lsb;
      default: w_ser_nxt = 1'b0;
    endcase
  end

  // Each payload bit is consumed as it is registered onto the line.
  assign w_shift    = (w_state_nxt == ST_DATA);
  assign w_done_nxt = (w_state_nxt == ST_GAP) && (r_state != ST_GAP);

  piso_shift_reg #(.W(DATA_W)) u_payload (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_data  (in_data),
    .i_shift (w_shift),
    .o_lsb   (w_piso_lsb)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      serOut  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_len <= in_len;
      serOut  <= w_ser_nxt;
      busy    <= (w_state_nxt != ST_IDLE);
      done    <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_sender.sv
// Scoreboard bench: stimulus pushes hand-written expected line bits per frame,
// a negedge monitor pops one entry per busy cycle and compares serOut/done.
module tb_serial_frame_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_len = '0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       serOut;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic ser;
    logic done;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  serial_frame_sender dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_len   (in_len),
    .in_data  (in_data),
    .serOut   (serOut),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line content: nbits frame bits (MSB of 'bits' first), then 10 gap zeros with done on the first.
  task automatic push_frame(input logic [31:0] bits, input int nbits);
    exp_t e;
    for (int i = nbits - 1; i >= 0; i--) begin
      e.ser  = bits[i];
      e.done = 1'b0;
      q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      e.ser  = 1'b0;
      e.done = (i == 0);
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        check("expected_entry_available", (q.size() != 0), 1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("serOut", serOut, mon_e.ser);
          check("done", done, mon_e.done);
        end
      end else begin
        check("idle_serOut", serOut, 0);
        check("idle_done", done, 0);
      end
    end
  end

  task automatic send(input logic [2:0] len, input logic [7:0] data,
                      input logic [31:0] bits, input int nbits,
                      input int ready_wait, input bit churn);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_len   = len;
    in_data  = data;
    @(posedge clk);
    push_frame(bits, nbits);
    #1;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      if (churn) begin
        in_valid = 1'b1;
        in_len   = 3'($urandom);
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    check("accept_to_ready_edges", k, ready_wait);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serOut", serOut, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready_low", in_ready, 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_in_ready", in_ready, 1);
      check("idle_busy", busy, 0);
    end

    // Valid coinciding with reset must not start a frame.
    in_valid = 1'b1;
    in_len   = 3'd3;
    in_data  = 8'h05;
    rst      = 1'b0;
    @(posedge clk); #1;
    check("valid_during_rst_busy", busy, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    check("after_rst_valid_busy", busy, 0);

    send(3'd3, 8'h05, 32'b1101011101, 10, 20, 1'b0);
    send(3'd0, 8'h00, 32'b1101000, 7, 17, 1'b0);
    send(3'd7, 8'hA5, 32'b11011111010010, 14, 24, 1'b1);

    // Reset in the middle of the length field abandons the frame.
    in_valid = 1'b1;
    in_len   = 3'd3;
    in_data  = 8'h05;
    @(posedge clk);
    push_frame(32'b1101011101, 10);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midframe_busy_before_rst", busy, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midframe_rst_serOut", serOut, 0);
    check("midframe_rst_busy", busy, 0);
    check("midframe_rst_done", done, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    send(3'd2, 8'h02, 32'b110101001, 9, 19, 1'b0);
    send(3'd5, 8'h1B, 32'b110110111011, 12, 22, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
